npu_out_writer: RTL and testbench
=================================

NPU_OUT_WRITER -- requirements
Module: npu_out_writer

Interface
REQ-001 Parameter PIXELS, default 1024, output pixels per layer (32x32 fmap).
REQ-002 Parameter OC_GROUPS, default 5, 16-channel output groups per pixel (80 out channels).
REQ-003 Parameter FIFO_DEPTH, default 4, capture buffer depth in 128-bit words, power of 2.
REQ-004 Parameter RELU_EN, default 1, 1 = per-byte ReLU on written data.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle pulse, begins a layer capture.
REQ-008 acc_done  input  1  one-cycle pulse, mac_data_out holds a finished accumulation this cycle.
REQ-009 mac_data_out  input  128  16 signed int8 results; byte q = bits [8q+7:8q] = output channel group*16+q.
REQ-010 wr_valid  output  1  write request to output fmap buffer.
REQ-011 wr_ready  input  1  buffer accepts the word when wr_valid & wr_ready.
REQ-012 wr_addr  output  16  word address = pixel*OC_GROUPS + group.
REQ-013 wr_data  output  128  result word after optional ReLU.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  one-cycle pulse, layer fully written.
REQ-016 overflow  output  1  sticky, a capture was dropped because FIFO was full.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE: start -> RUN; clears capture count, write address, FIFO pointers, overflow.
REQ-019 IDLE: acc_done ignored, nothing captured.
REQ-020 RUN: each acc_done pushes mac_data_out into FIFO and increments capture count.
REQ-021 RUN: capture count reaching PIXELS*OC_GROUPS -> DRAIN on the same edge as the final push; further acc_done ignored in DRAIN and DONE.
REQ-022 DRAIN: FIFO empty and no transfer pending -> DONE; DONE asserts done for exactly one cycle, then IDLE.
REQ-023 start while not IDLE is ignored.
REQ-024 FIFO is first-word-fall-through: wr_valid = FIFO not empty; wr_data/wr_addr reflect FIFO head.
REQ-025 Latency: acc_done sampled at edge N with FIFO empty -> wr_valid high after edge N (next cycle).
REQ-026 Transfer on wr_valid & wr_ready pops head and increments wr_addr by 1; wr_addr wraps only by restart, never past PIXELS*OC_GROUPS-1.
REQ-027 wr_valid, wr_addr, wr_data stable while wr_valid & !wr_ready.
REQ-028 Push and pop in the same cycle: both occur, occupancy unchanged, including when full.
REQ-029 acc_done while full and no pop same cycle: word dropped, capture count still increments, overflow set until next start; wr_addr for later words still advances per written word only.
REQ-030 ReLU: when RELU_EN=1 each byte with bit7=1 becomes 8'h00, else unchanged; RELU_EN=0 passes bytes untouched; applied at FIFO input.
REQ-031 busy = state != IDLE.

Reset
REQ-032 rstn low: state IDLE, FIFO empty, wr_valid 0, wr_addr 0, wr_data 0, busy 0, done 0, overflow 0, counters 0.
REQ-033 Reset mid-layer abandons the layer; no write issued after rstn low until a new start.

Verification
REQ-034 start, 5120 acc_done spaced 4 cycles, wr_ready=1 -> 5120 writes, addr 0..5119 in order, done once, overflow 0.
REQ-035 acc_done with mac_data_out = {16{8'h85}}, RELU_EN=1 -> wr_data 128'h0; RELU_EN=0 -> {16{8'h85}}; byte 8'h7F passes as 8'h7F.
REQ-036 wr_ready=0 for 40 cycles, acc_done every 4 cycles -> FIFO holds 4 words, 5th capture dropped, overflow=1 sticky; after wr_ready=1 the 4 held words write addr 0..3 unchanged.
REQ-037 FIFO full with acc_done and wr_ready=1 in same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-038 acc_done before start and after DRAIN entry -> no writes, capture count unchanged; start during RUN -> ignored, addresses continue.
REQ-039 rstn pulled low after 100 writes -> all outputs reset values within the cycle; new start restarts at wr_addr 0.

Source files
------------

// File: rtl/npu_out_writer.sv
// ---------------------------------------------------------------------------
// npu_out_writer
//
// Captures the finished 128-bit accumulation words of one NPU layer into a
// small first-word-fall-through buffer and writes them to the output fmap
// buffer over a valid/ready port. The write address is pixel*OC_GROUPS+group,
// which is simply the running count of words actually written.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rstn         in   asynchronous active-low reset
//   start        in   one-cycle pulse, begins a layer capture (IDLE only)
//   acc_done     in   one-cycle pulse, mac_data_out holds a result word
//   mac_data_out in   16 signed int8 results, byte q = channel group*16+q
//   wr_valid     out  write request (buffer not empty)
//   wr_ready     in   output buffer accepts the word
//   wr_addr      out  word address of the buffer head
//   wr_data      out  buffer head (ReLU already applied)
//   busy         out  layer in progress
//   done         out  one-cycle pulse, layer fully written
//   overflow     out  sticky, a capture was dropped on a full buffer
// ---------------------------------------------------------------------------
module npu_out_writer #(
    parameter int PIXELS     = 1024,
    parameter int OC_GROUPS  = 5,
    parameter int FIFO_DEPTH = 4,   // power of 2, at least 2
    parameter int RELU_EN    = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         acc_done,
    input  logic [127:0] mac_data_out,
    output logic         wr_valid,
    input  logic         wr_ready,
    output logic [15:0]  wr_addr,
    output logic [127:0] wr_data,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int TOTAL = PIXELS * OC_GROUPS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cap_cnt;
    logic [PTR_W:0]     wr_ptr, rd_ptr;   // extra MSB tells full from empty
    logic [127:0]       mem [FIFO_DEPTH];

    logic fifo_empty, fifo_full;
    logic start_ok, capture, push, pop, drop;

    // Negative int8 results clamp to zero; applied before the buffer so the
    // stored word is already final.
    function automatic logic [127:0] relu(input logic [127:0] d);
        logic [127:0] r;
        r = d;
        for (int q = 0; q < 16; q++) begin
            if ((RELU_EN != 0) && d[8*q+7])
                r[8*q +: 8] = 8'h00;
        end
        return r;
    endfunction

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign start_ok = (state == IDLE) && start;
    assign capture  = (state == RUN) && acc_done;
    assign pop      = !fifo_empty && wr_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push     = capture && (!fifo_full || pop);
    assign drop     = capture && fifo_full && !pop;

    // NOTE: the word storage has no reset; wr_data is forced to zero while
    // the buffer is empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= relu(mac_data_out);
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // process sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cap_cnt  <= '0;
            wr_addr  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cap_cnt  <= '0;
                wr_addr  <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + (PTR_W+1)'(1);
                if (pop) begin
                    rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
                    wr_addr <= wr_addr + 16'd1;
                end
                // Dropped captures still count towards the layer total.
                if (capture)
                    cap_cnt <= cap_cnt + CNT_W'(1);
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (capture && (cap_cnt == CNT_W'(TOTAL - 1))) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_valid = !fifo_empty;
    assign wr_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_npu_out_writer.sv
// ---------------------------------------------------------------------------
// tb_npu_out_writer
//
// Self-checking bench for npu_out_writer. A queue-based reference model of
// the layer (capture count, 4-deep buffer, drop rule, written-word address)
// is checked against the DUT on every falling edge; directed sequences and a
// ReLU vector table cover the corner cases. A second instance with
// RELU_EN=0 and a one-word layer checks the pass-through data path.
// ---------------------------------------------------------------------------
module tb_npu_out_writer;

    localparam int PIX   = 1024;
    localparam int OCG   = 5;
    localparam int TOTAL = PIX * OCG;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic         acc_done = 1'b0;
    logic         wr_ready = 1'b0;
    logic [127:0] mac_data_out = '0;

    logic         wr_valid, busy, done, overflow;
    logic [15:0]  wr_addr;
    logic [127:0] wr_data;

    logic         raw_wr_valid, raw_busy, raw_done, raw_overflow;
    logic [15:0]  raw_wr_addr;
    logic [127:0] raw_wr_data;

    npu_out_writer #(.PIXELS(PIX), .OC_GROUPS(OCG), .FIFO_DEPTH(DEPTH), .RELU_EN(1)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .acc_done(acc_done),
        .mac_data_out(mac_data_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .overflow(overflow)
    );

    npu_out_writer #(.PIXELS(1), .OC_GROUPS(1), .FIFO_DEPTH(DEPTH), .RELU_EN(0)) u_raw (
        .clk(clk), .rstn(rstn), .start(start2), .acc_done(acc_done),
        .mac_data_out(mac_data_out), .wr_valid(raw_wr_valid), .wr_ready(wr_ready),
        .wr_addr(raw_wr_addr), .wr_data(raw_wr_data), .busy(raw_busy), .done(raw_done),
        .overflow(raw_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [127:0] m_q[$];
    int  m_addr = 0;
    int  m_cnt  = 0;
    bit  m_busy = 0, m_run = 0, m_drain = 0, m_done = 0, m_ovf = 0;
    bit  m_was_empty, m_pop, m_run_pre;
    int  nwrites = 0;
    int  ndone   = 0;

    function automatic logic [127:0] relu_ref(input logic [127:0] d);
        logic [127:0] r;
        byte signed b;
        for (int q = 0; q < 16; q++) begin
            b = d[8*q +: 8];
            r[8*q +: 8] = (b < 0) ? 8'd0 : d[8*q +: 8];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_q.delete();
            m_addr = 0; m_cnt = 0;
            m_busy = 0; m_run = 0; m_drain = 0; m_done = 0; m_ovf = 0;
        end else begin
            m_was_empty = (m_q.size() == 0);
            m_pop       = !m_was_empty && wr_ready;
            m_run_pre   = m_run;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_drain && m_was_empty) begin
                m_drain = 0;
                m_done  = 1;
            end else if (!m_busy && start) begin
                m_busy = 1; m_run = 1; m_cnt = 0; m_addr = 0; m_ovf = 0;
            end
            if (m_pop) begin
                void'(m_q.pop_front());
                m_addr++;
            end
            if (m_run_pre && acc_done) begin
                if (m_q.size() < DEPTH) m_q.push_back(relu_ref(mac_data_out));
                else m_ovf = 1;
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_run   = 0;
                    m_drain = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("wr_valid", wr_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("wr_addr", wr_addr, m_addr);
                check("wr_data", wr_data, m_q[0]);
            end
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("overflow", overflow, m_ovf);
            if (wr_valid && wr_ready) nwrites++;
            if (done) ndone++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_acc(input logic [127:0] d);
        acc_done = 1'b1;
        mac_data_out = d;
        tick();
        acc_done = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_wr_addr"},  wr_addr,  0);
        check({tag, "_wr_data"},  wr_data,  0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] relu_exp;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, d0, guard, caps;

        tbl[0] = '{ {16{8'h85}}, 128'h0 };
        tbl[1] = '{ {16{8'h7F}}, {16{8'h7F}} };
        tbl[2] = '{ {8{8'h80, 8'h01}}, {8{8'h00, 8'h01}} };
        tbl[3] = '{ {16{8'hFF}}, 128'h0 };
        tbl[4] = '{ 128'h0, 128'h0 };
        tbl[5] = '{ 128'h0123_4567_89AB_CDEF_F0E1_D2C3_B4A5_9687,
                    128'h0123_4567_0000_0000_0000_0000_0000_0000 };

        // Reset values
        tick(2);
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // acc_done before start must not capture
        wr_ready = 1'b1;
        repeat (3) begin
            pulse_acc(rand128());
            tick();
        end
        tick(3);
        check("no_write_before_start", nwrites, 0);

        // ReLU vector table, both instances
        for (int i = 0; i < 6; i++) begin
            wr_ready = 1'b0;
            start = 1'b1; start2 = 1'b1;
            tick();
            start = 1'b0; start2 = 1'b0;
            pulse_acc(tbl[i].din);
            check("latency_valid", wr_valid, 1);
            check("relu_data", wr_data, tbl[i].relu_exp);
            check("raw_data", raw_wr_data, tbl[i].din);
            wr_ready = 1'b1;
            tick(3);
            check("raw_idle", raw_busy, 0);
        end
        do_reset();

        // Stalled output: 4 held, later captures dropped, sticky overflow
        pulse_start();
        wr_ready = 1'b0;
        repeat (10) begin
            pulse_acc(rand128());
            tick(3);
        end
        check("stall_overflow", overflow, 1);
        check("stall_valid", wr_valid, 1);
        check("stall_addr", wr_addr, 0);
        w0 = nwrites;
        wr_ready = 1'b1;
        tick(4);
        check("stall_held_writes", nwrites - w0, 4);
        check("stall_empty", wr_valid, 0);
        check("stall_overflow_sticky", overflow, 1);
        do_reset();

        // Full buffer with simultaneous push and pop: no drop
        pulse_start();
        wr_ready = 1'b0;
        repeat (4) pulse_acc(rand128());
        check("full_no_ovf", overflow, 0);
        acc_done = 1'b1; mac_data_out = rand128(); wr_ready = 1'b1;
        tick();
        acc_done = 1'b0; wr_ready = 1'b0;
        check("pushpop_no_ovf", overflow, 0);
        pulse_acc(rand128());
        check("still_full_drops", overflow, 1);
        do_reset();

        // Reset mid-layer after 100 writes, then restart from address 0
        pulse_start();
        wr_ready = 1'b1;
        w0 = nwrites;
        guard = 0;
        while ((nwrites - w0) < 100 && guard < 1000) begin
            pulse_acc(rand128());
            tick();
            guard++;
        end
        check("reached_100_writes", (nwrites - w0) >= 100, 1);
        wr_ready = 1'b0;
        repeat (5) pulse_acc(rand128());
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        tick();
        rstn = 1'b1;
        tick();
        wr_ready = 1'b1;
        w0 = nwrites;
        repeat (2) begin
            pulse_acc(rand128());
            tick();
        end
        check("no_write_after_reset", nwrites - w0, 0);
        pulse_start();
        wr_ready = 1'b0;
        pulse_acc(rand128());
        check("restart_valid", wr_valid, 1);
        check("restart_addr", wr_addr, 0);
        wr_ready = 1'b1;
        do_reset();

        // Full layer, wr_ready=1, captures every 4 cycles, extra acc_done in DRAIN
        pulse_start();
        wr_ready = 1'b1;
        w0 = nwrites;
        d0 = ndone;
        for (int k = 0; k < TOTAL - 1; k++) begin
            pulse_acc(rand128());
            tick(3);
        end
        pulse_acc(rand128());
        pulse_acc(rand128());
        guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        check("layer_finished", busy, 0);
        check("layer_writes", nwrites - w0, TOTAL);
        check("layer_done_once", ndone - d0, 1);
        check("layer_overflow", overflow, 0);

        // Randomized layer: random ready, spacing, and ignored restarts
        pulse_start();
        w0 = nwrites;
        d0 = ndone;
        caps = 0;
        guard = 0;
        while (caps < TOTAL && guard < 40000) begin
            wr_ready     = ($urandom_range(0, 9) < 7);
            start        = ($urandom_range(0, 63) == 0);
            acc_done     = ($urandom_range(0, 2) == 0);
            mac_data_out = rand128();
            if (acc_done) caps++;
            tick();
            guard++;
        end
        acc_done = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b1;
        guard = 0;
        while (busy && guard < 100) begin
            tick();
            guard++;
        end
        check("rand_finished", busy, 0);
        check("rand_done_once", ndone - d0, 1);
        check("rand_writes", nwrites - w0, m_addr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
